uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Consumes the byte stream out of the UART receiver (parallel data, valid strobe, parity and stop error flags) and decodes it into register-file accesses. Write frames become single-cycle write strobes. Read frames issue a read strobe, capture the returned data and present it on a valid/ready response port that feeds the UART transmit path. It sits directly downstream of the UART receiver, in the RX clock domain.

Parameters:
DATA_WIDTH, 8, width of UART bytes, register data and response data
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
TIMEOUT_CYCLES, 4096, max CLK cycles allowed between bytes of one frame and for read-data return
WR_OPCODE, 8'hAA, opcode byte of a write frame
RD_OPCODE, 8'hBB, opcode byte of a read frame

Ports:
CLK  in  1  block clock (UART RX clock)
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
PAR_ERR  in  1  parity error, qualified by RX_D_VLD
STP_ERR  in  1  framing error, qualified by RX_D_VLD
WrEn  out  1  register write strobe
RdEn  out  1  register read strobe
Address  out  ADDR_WIDTH  register address
WrData  out  DATA_WIDTH  register write data
RdData  in  DATA_WIDTH  register read data
RdData_Valid  in  1  RdData valid strobe
RSP_DATA  out  DATA_WIDTH  response byte toward the TX path
RSP_VLD  out  1  response valid
RSP_READY  in  1  response accepted
FRAME_ERR  out  1  one-cycle pulse on any aborted frame

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is asynchronous and active-low.
- Reset: all outputs are 0; FSM goes to IDLE; timeout counter is 0.
- A byte is "accepted" on a cycle with RX_D_VLD=1 and PAR_ERR=0 and STP_ERR=0.
- A byte with PAR_ERR or STP_ERR set, in any receive state: the frame is aborted, the FSM goes to IDLE, and FRAME_ERR pulses on the next cycle.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RSP.
- IDLE:
  - Accepted byte == WR_OPCODE -> WR_ADDR.
  - Accepted byte == RD_OPCODE -> RD_ADDR.
  - Any other accepted byte is silently discarded; FSM stays in IDLE; no FRAME_ERR.
- WR_ADDR: accepted byte -> Address <= byte[ADDR_WIDTH-1:0] (upper bits ignored); go to WR_DATA.
- WR_DATA: accepted byte -> WrData <= byte and WrEn=1 for exactly one cycle, in the cycle after the RX_D_VLD cycle; go to IDLE. Address and WrData hold their values until the next frame overwrites them.
- RD_ADDR: accepted byte -> Address latched; RdEn=1 for exactly one cycle, in the cycle after the RX_D_VLD cycle; go to RD_WAIT.
- RD_WAIT: on RdData_Valid=1 -> RSP_DATA <= RdData; RSP_VLD=1 from the next cycle; go to RSP. RdData_Valid in the same cycle as RdEn is legal.
- RSP:
  - RSP_VLD and RSP_DATA are held stable until a cycle with RSP_READY=1.
  - That handshake cycle is the transfer; RSP_VLD=0 on the next cycle and FSM goes to IDLE.
  - RSP_READY=1 while RSP_VLD=0 has no effect.
- RX bytes arriving in RD_WAIT or RSP are dropped: no state change and no FRAME_ERR.
- Timeout counter:
  - Clears on every accepted byte and on entry to any non-IDLE state.
  - Increments each cycle in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - Reaching TIMEOUT_CYCLES-1 -> FSM goes to IDLE and FRAME_ERR pulses.
  - Held at 0 in IDLE and RSP; RSP never times out.
- Reset asserted mid-frame discards all partial state immediately and asynchronously.

Optional Feature:
UART_CMD_ERR_RSP_EN
- Defined: every FRAME_ERR event also queues a response byte 8'hEE through the RSP state using the same valid/ready rules. FRAME_ERR still pulses.
- Not defined: errors only pulse FRAME_ERR and return the FSM to IDLE.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the opcode defaults 8'hAA and 8'hBB;
  - the error response constant 8'hEE;
  - the default TIMEOUT_CYCLES.
- One sub-module, uart_cmd_timeout: a counter with clear and enable inputs and a single expire output, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Write frame: send AA,05,3C with no gaps -> one WrEn pulse, Address=4'h5, WrData=8'h3C, no RdEn, no FRAME_ERR.
- Read frame: send BB,07; bench returns RdData=8'h5A 3 cycles after RdEn with RSP_READY held 0 for 10 cycles -> RdEn pulses once, Address=4'h7, RSP_VLD rises and stays high with RSP_DATA=8'h5A; RSP_READY=1 for one cycle -> RSP_VLD drops.
- Parity error: send AA, then 05 with PAR_ERR=1 -> FRAME_ERR pulses once, no WrEn; a following AA,01,FF performs a normal write.
- Timeout: send AA,02 then idle for TIMEOUT_CYCLES cycles -> FRAME_ERR pulses, FSM in IDLE; a later byte 3C alone produces no WrEn.
- Junk and mid-frame reset: send 11,22 -> no activity. Send AA,09, assert RST low for 2 cycles, release, send 44 -> no WrEn, all outputs 0 during reset.
- With UART_CMD_ERR_RSP_EN defined: a framing error on the second byte -> RSP_VLD=1 with RSP_DATA=8'hEE until RSP_READY.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared state encoding and constants for the UART command parser.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    localparam logic [7:0] c_WR_OPCODE      = 8'hAA;
    localparam logic [7:0] c_RD_OPCODE      = 8'hBB;
    localparam logic [7:0] c_ERR_RSP        = 8'hEE;
    localparam int         c_TIMEOUT_CYCLES = 4096;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_timeout
// Description : Inter-byte / read-return watchdog; expires at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int                 c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Saturates at the terminal value so a stalled enable cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Decodes UART RX bytes into register writes/reads and a read
//               response stream. Option UART_CMD_ERR_RSP_EN: errors also emit
//               an 8'hEE response byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] WR_OPCODE      = DATA_WIDTH'(c_WR_OPCODE),
    parameter logic [DATA_WIDTH-1:0] RD_OPCODE      = DATA_WIDTH'(c_RD_OPCODE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  STP_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_VLD,
    input  logic                  RSP_READY,
    output logic                  FRAME_ERR
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_frame_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_accept;
    logic                  w_bad;
    logic                  w_rx_state;
    logic                  w_err;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_expire;
    logic                  w_rsp_load;
    logic [DATA_WIDTH-1:0] w_rsp_din;

    assign w_accept   = RX_D_VLD & ~PAR_ERR & ~STP_ERR;
    assign w_bad      = RX_D_VLD & (PAR_ERR | STP_ERR);
    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_WR_ADDR) ||
                        (r_state == S_WR_DATA) || (r_state == S_RD_ADDR);

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_cnt_en   = 1'b0;
        w_rsp_load = 1'b0;
        w_rsp_din  = RdData;
        case (r_state)
            S_IDLE: begin
                if (w_accept && RX_P_DATA == WR_OPCODE)      w_next = S_WR_ADDR;
                else if (w_accept && RX_P_DATA == RD_OPCODE) w_next = S_RD_ADDR;
            end
            S_WR_ADDR: begin
                w_cnt_en = 1'b1;
                if (w_accept) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                w_cnt_en = 1'b1;
                if (w_accept) w_next = S_IDLE;
            end
            S_RD_ADDR: begin
                w_cnt_en = 1'b1;
                if (w_accept) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_cnt_en = 1'b1;
                if (RdData_Valid) begin
                    w_next     = S_RSP;
                    w_rsp_load = 1'b1;
                end
            end
            S_RSP: begin
                if (RSP_READY) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Bad bytes abort; timeout only fires when the cycle made no progress.
        if ((w_rx_state && w_bad) || (w_cnt_en && w_expire && w_next == r_state)) begin
            w_err = 1'b1;
`ifdef UART_CMD_ERR_RSP_EN
            w_next     = S_RSP;
            w_rsp_load = 1'b1;
            w_rsp_din  = DATA_WIDTH'(c_ERR_RSP);
`else
            w_next     = S_IDLE;
`endif
        end
    end

    assign w_cnt_clr = w_accept || (w_next != r_state) || !w_cnt_en;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLK),
        .rst_n    (RST),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_frame_err <= w_err;
            r_wr_en     <= (r_state == S_WR_DATA) && w_accept;
            r_rd_en     <= (r_state == S_RD_ADDR) && w_accept;
            if (((r_state == S_WR_ADDR) || (r_state == S_RD_ADDR)) && w_accept)
                r_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            if ((r_state == S_WR_DATA) && w_accept)
                r_wr_data <= RX_P_DATA;
            if (w_rsp_load)
                r_rsp_data <= w_rsp_din;
        end
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_VLD   = (r_state == S_RSP);
    assign FRAME_ERR = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Scoreboard bench for uart_cmd_parser (honours UART_CMD_ERR_RSP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int c_TO = 4096;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0, PAR_ERR = 1'b0, STP_ERR = 1'b0;
    logic       WrEn, RdEn, RSP_VLD, FRAME_ERR;
    logic [3:0] Address;
    logic [7:0] WrData, RSP_DATA;
    logic [7:0] RdData = '0;
    logic       RdData_Valid = 1'b0;
    logic       RSP_READY = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] wr_q[$];   // {addr, data}
    logic [3:0]  rd_q[$];
    logic [7:0]  rsp_q[$];
    logic        err_q[$];

    uart_cmd_parser dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .WrEn(WrEn), .RdEn(RdEn),
        .Address(Address), .WrData(WrData), .RdData(RdData),
        .RdData_Valid(RdData_Valid), .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD),
        .RSP_READY(RSP_READY), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge CLK) begin
        if (WrEn) begin
            if (wr_q.size() == 0) chk("wren_unexp", WrEn, 0);
            else chk("wr_addr_data", {Address, WrData}, wr_q.pop_front());
        end
        if (RdEn) begin
            if (rd_q.size() == 0) chk("rden_unexp", RdEn, 0);
            else chk("rd_addr", Address, rd_q.pop_front());
        end
        if (RSP_VLD && RSP_READY) begin
            if (rsp_q.size() == 0) chk("rsp_unexp", RSP_VLD, 0);
            else chk("rsp_data", RSP_DATA, rsp_q.pop_front());
        end
        if (FRAME_ERR) begin
            if (err_q.size() == 0) chk("ferr_unexp", FRAME_ERR, 0);
            else void'(err_q.pop_front());
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input logic par = 1'b0, input logic stp = 1'b0);
        RX_P_DATA = b; RX_D_VLD = 1'b1; PAR_ERR = par; STP_ERR = stp;
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wren"}, WrEn, 0);
        chk({tag, "_rden"}, RdEn, 0);
        chk({tag, "_addr"}, Address, 0);
        chk({tag, "_wrdata"}, WrData, 0);
        chk({tag, "_rspdata"}, RSP_DATA, 0);
        chk({tag, "_rspvld"}, RSP_VLD, 0);
        chk({tag, "_ferr"}, FRAME_ERR, 0);
    endtask

    task automatic ack_err();
`ifdef UART_CMD_ERR_RSP_EN
        rsp_q.push_back(8'hEE);
        chk("err_rsp_vld", RSP_VLD, 1);
        chk("err_rsp_data", RSP_DATA, 8'hEE);
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        chk("err_rsp_drop", RSP_VLD, 0);
`else
        chk("no_err_rsp", RSP_VLD, 0);
`endif
    endtask

    initial begin
        int  n;
        bit  got;
        #2 RST = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        // Write frame, back-to-back bytes
        wr_q.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C); idle(5);
        chk("wr_hold_addr", Address, 4'h5);
        chk("wr_hold_data", WrData, 8'h3C);

        // Read frame with delayed return and back-pressured response
        rd_q.push_back(4'h7);
        rsp_q.push_back(8'h5A);
        send(8'hBB); send(8'h07); idle(0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (RdEn) begin got = 1'b1; break; end
            @(posedge CLK); #1;
        end
        chk("rden_seen", got, 1);
        repeat (3) begin @(posedge CLK); #1; end
        RdData = 8'h5A; RdData_Valid = 1'b1;
        @(posedge CLK); #1;
        RdData_Valid = 1'b0; RdData = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("rsp_hold_vld", RSP_VLD, 1);
            chk("rsp_hold_data", RSP_DATA, 8'h5A);
            @(posedge CLK); #1;
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        chk("rsp_drop", RSP_VLD, 0);
        idle(2);

        // Parity error mid-frame, then recovery
        err_q.push_back(1'b1);
        send(8'hAA); send(8'h05, 1'b1, 1'b0); idle(3);
        ack_err();
        wr_q.push_back({4'h1, 8'hFF});
        send(8'hAA); send(8'h01); send(8'hFF); idle(3);

        // Timeout after address byte
        err_q.push_back(1'b1);
        send(8'hAA); send(8'h02); idle(0);
        n = 0;
        while (!FRAME_ERR && n < 2 * c_TO) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("timeout_cycles", n, c_TO);
        @(posedge CLK); #1;
        ack_err();
        send(8'h3C); idle(5);
        wr_q.push_back({4'h3, 8'h44});
        send(8'hAA); send(8'h13); send(8'h44); idle(3);

        // Junk bytes are discarded silently
        send(8'h11); send(8'h22); idle(5);
        chk("junk_rspvld", RSP_VLD, 0);

        // Mid-frame asynchronous reset
        send(8'hAA); send(8'h09); idle(0);
        RST = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b1;
        send(8'h44); idle(5);

        // Framing error on second byte
        err_q.push_back(1'b1);
        send(8'hBB); send(8'h03, 1'b0, 1'b1); idle(2);
        ack_err();
        idle(5);

        chk("wr_q_left", wr_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        chk("rsp_q_left", rsp_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
